fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter TAM_ENTRADA, default 1024: instruction ROM depth in 32-bit words.
REQ-002 The block SHALL have parameter TAM_SALIDA, default 32: instruction width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: CLK  in  1  rising-edge clock.
REQ-006 Port: RESET  in  1  synchronous active-high reset.
REQ-007 Port: rom_addr  out  $clog2(TAM_ENTRADA)  word address to the asynchronous ROM.
REQ-008 Port: rom_data  in  TAM_SALIDA  ROM read data, combinational from rom_addr.
REQ-009 Port: branch_taken  in  1  redirect request, valid for one cycle.
REQ-010 Port: branch_target  in  32  byte address of the redirect.
REQ-011 Port: out_ready  in  1  decode stage accepts instr_out this cycle.
REQ-012 Port: out_valid  out  1  instr_out/pc_out hold a valid instruction.
REQ-013 Port: instr_out  out  TAM_SALIDA  fetched instruction.
REQ-014 Port: pc_out  out  32  byte address of instr_out.
REQ-015 Port: fault  out  1  sticky fetch fault (misaligned or out-of-range address).
REQ-016 Port: fetch_count  out  32  number of instructions accepted by decode (out_valid & out_ready).

Function
REQ-017 The block SHALL hold the internal PC register pc_q (byte address) and drive rom_addr = pc_q[$clog2(TAM_ENTRADA)+1:2] combinationally.
REQ-018 The FSM SHALL have states IDLE, RUN, FAULT; IDLE→RUN after one cycle unconditionally; RUN→FAULT on a fault condition; FAULT is left only by RESET.
REQ-019 In RUN, when (!out_valid | out_ready) and no branch, the block SHALL register instr_out<=rom_data, pc_out<=pc_q, out_valid<=1, pc_q<=pc_q+4.
REQ-020 In RUN, when out_valid & !out_ready, all outputs and pc_q SHALL hold (stall, no data loss).
REQ-021 Fetch latency SHALL be one cycle: address presented in cycle t, instruction valid on outputs in cycle t+1.
REQ-022 branch_taken SHALL have priority over stall and sequential fetch: at the next edge pc_q<=branch_target and out_valid<=0 (flush); the first target instruction is valid two cycles after branch_taken.
REQ-023 branch_taken in IDLE or FAULT SHALL be ignored.
REQ-024 A branch_target with bits[1:0]!=0, or with word index >= TAM_ENTRADA, SHALL cause the FAULT state at the next edge, with out_valid<=0 and fault<=1.
REQ-025 A sequential increment of pc_q past word TAM_ENTRADA-1 SHALL cause FAULT; the last word itself SHALL be delivered normally, and no wrap to 0 SHALL occur.
REQ-026 In FAULT, out_valid SHALL be 0, pc_q SHALL hold, and fetch_count SHALL hold.
REQ-027 fetch_count SHALL increment by 1 on each cycle with out_valid & out_ready, wrap modulo 2^32, and also count the transfer in the cycle a branch flushes.

Reset
REQ-028 On RESET=1 at a clock edge, the block SHALL set state=IDLE, pc_q=RESET_PC, out_valid=0, instr_out=32'h0000_0013 (NOP), pc_out=0, fault=0, fetch_count=0.
REQ-029 RESET SHALL override branch_taken, stall and fault in the same cycle, including when asserted mid-stall or in FAULT.
REQ-030 An out-of-range or misaligned RESET_PC SHALL enter FAULT on the IDLE→RUN transition.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, RUN, FAULT), the NOP constant 32'h0000_0013, and the PC width constant 32.
REQ-032 The ROM SHALL be instantiated by the parent and not inside this block.
REQ-033 One sub-module, fetch_out_reg (the output register stage with valid/hold), is natural; the FSM, PC and counter SHALL remain in fetch_sequencer.

Verification
REQ-034 Reset, then out_ready=1 with ROM words 0..3 = 0xA0..0xA3 SHALL give out_valid rising 2 cycles after RESET falls, then pc_out 0,4,8,12 with instr_out 0xA0..0xA3 on consecutive cycles.
REQ-035 out_ready=0 for 3 cycles while pc_out=8 SHALL hold instr_out/pc_out stable; after release pc_out=12 follows with no skipped or duplicated word, and fetch_count increases by exactly 1 per transfer.
REQ-036 branch_taken with target 0x40 while stalled SHALL give out_valid=0 next cycle, then pc_out=0x40 with instr_out=ROM[16].
REQ-037 branch_target 0x42, or 0x1000 with TAM_ENTRADA=1024, SHALL set fault=1 and out_valid=0 permanently until RESET; RESET SHALL restore pc_out fetch from RESET_PC.
REQ-038 Sequential run from 0xFF8 with TAM_ENTRADA=1024 SHALL deliver pc_out 0xFF8 and 0xFFC, then assert fault; RESET asserted together with branch_taken SHALL leave pc_q=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the NOP reset word and the address-legality helper.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int PC_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A byte address is illegal when it is not word aligned or lies beyond the ROM.
    function automatic logic addr_fault(input logic [PC_WIDTH-1:0] addr,
                                        input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[PC_WIDTH-1:2]} >= depth);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Output register stage of the fetch sequencer: captures an instruction/PC pair,
// holds it while decode stalls, and drops it on a flush.
module fetch_out_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                flush,
    input  logic [DATA_W-1:0]   instr_in,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                out_valid,
    output logic [DATA_W-1:0]   instr_out,
    output logic [PC_WIDTH-1:0] pc_out
);

    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    // Flush wins over load so a redirect never lets a stale word through.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= DATA_W'(NOP_INSTR);
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks an external asynchronous ROM, handles branch
// redirects and decode back-pressure, and latches a sticky fault on illegal addresses.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          TAM_ENTRADA = 1024,
    parameter int          TAM_SALIDA  = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                           CLK,
    input  logic                           RESET,
    output logic [$clog2(TAM_ENTRADA)-1:0] rom_addr,
    input  logic [TAM_SALIDA-1:0]          rom_data,
    input  logic                           branch_taken,
    input  logic [PC_WIDTH-1:0]            branch_target,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [TAM_SALIDA-1:0]          instr_out,
    output logic [PC_WIDTH-1:0]            pc_out,
    output logic                           fault,
    output logic [31:0]                    fetch_count
);

    localparam int          ADDR_W = $clog2(TAM_ENTRADA);
    localparam int unsigned DEPTH  = TAM_ENTRADA;

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                fault_q, fault_d;
    logic [31:0]         count_q, count_d;
    logic                load, flush;
    logic                transfer;

    assign rom_addr = pc_q[ADDR_W+1:2];
    assign transfer = out_valid & out_ready;

    // A fetch past the last ROM word only faults when it is actually attempted,
    // so the final word survives a decode stall and is still handed over.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q + {31'b0, transfer};
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (addr_fault(pc_q, DEPTH)) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (branch_taken) begin
                    flush = 1'b1;
                    if (addr_fault(branch_target, DEPTH)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (!out_valid || out_ready) begin
                    if (addr_fault(pc_q, DEPTH)) begin
                        flush   = 1'b1;
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            FAULT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = FAULT;
                fault_d = 1'b1;
                flush   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    fetch_out_reg #(
        .DATA_W (TAM_SALIDA)
    ) u_out_reg (
        .clk       (CLK),
        .reset     (RESET),
        .load      (load),
        .flush     (flush),
        .instr_in  (rom_data),
        .pc_in     (pc_q),
        .out_valid (out_valid),
        .instr_out (instr_out),
        .pc_out    (pc_out)
    );

    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run
// checked against an instruction-stream model (expected next PC and transfer count).
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        out_ready;
    logic [9:0]  rom_addr, rom_addr2;
    logic [31:0] rom_data, rom_data2;
    logic        out_valid, out_valid2;
    logic [31:0] instr_out, instr_out2;
    logic [31:0] pc_out, pc_out2;
    logic        fault, fault2;
    logic [31:0] fetch_count, fetch_count2;

    logic [31:0] rom [0:1023];
    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom[rom_addr2];

    fetch_sequencer #(.TAM_ENTRADA(1024), .TAM_SALIDA(32), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RESET(RESET), .rom_addr(rom_addr), .rom_data(rom_data),
        .branch_taken(branch_taken), .branch_target(branch_target), .out_ready(out_ready),
        .out_valid(out_valid), .instr_out(instr_out), .pc_out(pc_out),
        .fault(fault), .fetch_count(fetch_count)
    );

    // Second copy with a misaligned start address; it must fault on leaving IDLE.
    fetch_sequencer #(.TAM_ENTRADA(1024), .TAM_SALIDA(32), .RESET_PC(32'h2)) dut_badpc (
        .CLK(CLK), .RESET(RESET), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .branch_taken(branch_taken), .branch_target(branch_target), .out_ready(out_ready),
        .out_valid(out_valid2), .instr_out(instr_out2), .pc_out(pc_out2),
        .fault(fault2), .fetch_count(fetch_count2)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b1;
        repeat (6) step();
        RESET = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        step();
        RESET = 1'b0;
        branch_taken = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); else passed++;
        checks++; if (instr_out !== 32'h13) $display("[TB] FAIL reset_instr: got %h expected 00000013", instr_out); else passed++;
        checks++; if (pc_out !== 32'h0) $display("[TB] FAIL reset_pc_out: got %h expected 0", pc_out); else passed++;
        checks++; if (fault !== 1'b0) $display("[TB] FAIL reset_fault: got %0b expected 0", fault); else passed++;
        checks++; if (fetch_count !== 32'h0) $display("[TB] FAIL reset_count: got %0d expected 0", fetch_count); else passed++;
        checks++; if (rom_addr !== 10'h0) $display("[TB] FAIL reset_rom_addr: got %h expected 0", rom_addr); else passed++;
    endtask

    task automatic test_startup();
        do_reset();
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL startup_idle_valid: got %0b expected 0", out_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b1) $display("[TB] FAIL startup_valid%0d: got %0b expected 1", i, out_valid); else passed++;
            checks++; if (pc_out !== 32'(4 * i)) $display("[TB] FAIL startup_pc%0d: got %h expected %h", i, pc_out, 4 * i); else passed++;
            checks++; if (instr_out !== 32'hA0 + 32'(i)) $display("[TB] FAIL startup_instr%0d: got %h expected %h", i, instr_out, 32'hA0 + i); else passed++;
            checks++; if (fetch_count !== 32'(i)) $display("[TB] FAIL startup_count%0d: got %0d expected %0d", i, fetch_count, i); else passed++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (pc_out !== 32'h8) $display("[TB] FAIL stall_pc%0d: got %h expected 8", k, pc_out); else passed++;
            checks++; if (instr_out !== 32'hA2) $display("[TB] FAIL stall_instr%0d: got %h expected a2", k, instr_out); else passed++;
            checks++; if (out_valid !== 1'b1) $display("[TB] FAIL stall_valid%0d: got %0b expected 1", k, out_valid); else passed++;
            checks++; if (fetch_count !== 32'd2) $display("[TB] FAIL stall_count%0d: got %0d expected 2", k, fetch_count); else passed++;
        end
        out_ready = 1'b1;
        step();
        checks++; if (pc_out !== 32'hC) $display("[TB] FAIL release_pc: got %h expected c", pc_out); else passed++;
        checks++; if (fetch_count !== 32'd3) $display("[TB] FAIL release_count: got %0d expected 3", fetch_count); else passed++;
        step();
        checks++; if (pc_out !== 32'h10) $display("[TB] FAIL release_pc2: got %h expected 10", pc_out); else passed++;
        checks++; if (fetch_count !== 32'd4) $display("[TB] FAIL release_count2: got %0d expected 4", fetch_count); else passed++;
    endtask

    // Continues from test_stall: pc_out=0x10 is on the outputs, count=4.
    task automatic test_branch_stall();
        out_ready = 1'b0;
        step();
        branch_taken = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL br_flush_valid: got %0b expected 0", out_valid); else passed++;
        checks++; if (fetch_count !== 32'd4) $display("[TB] FAIL br_stall_count: got %0d expected 4", fetch_count); else passed++;
        step();
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL br_target_valid: got %0b expected 1", out_valid); else passed++;
        checks++; if (pc_out !== 32'h40) $display("[TB] FAIL br_target_pc: got %h expected 40", pc_out); else passed++;
        checks++; if (instr_out !== rom[16]) $display("[TB] FAIL br_target_instr: got %h expected %h", instr_out, rom[16]); else passed++;
        out_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        checks++; if (fetch_count !== 32'd5) $display("[TB] FAIL br_xfer_count: got %0d expected 5", fetch_count); else passed++;
        step();
        checks++; if (pc_out !== 32'h100 || instr_out !== rom[64]) $display("[TB] FAIL br2_target: got %h/%h expected 100/%h", pc_out, instr_out, rom[64]); else passed++;
    endtask

    task automatic test_bad_target();
        logic [31:0] targets [2];
        targets[0] = 32'h42;
        targets[1] = 32'h1000;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            out_ready = 1'b1;
            repeat (3) step();
            out_ready = 1'b0;
            branch_taken = 1'b1;
            branch_target = targets[t];
            step();
            checks++; if (fault !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL badtgt%0d_enter: got fault=%0b valid=%0b expected 1/0", t, fault, out_valid); else passed++;
            out_ready = 1'b1;
            branch_target = 32'h40;
            step();
            branch_taken = 1'b0;
            repeat (3) step();
            checks++; if (fault !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL badtgt%0d_sticky: got fault=%0b valid=%0b expected 1/0", t, fault, out_valid); else passed++;
            checks++; if (fetch_count !== 32'd1) $display("[TB] FAIL badtgt%0d_count: got %0d expected 1", t, fetch_count); else passed++;
            do_reset();
            out_ready = 1'b1;
            step();
            step();
            checks++; if (out_valid !== 1'b1 || pc_out !== 32'h0 || fault !== 1'b0) $display("[TB] FAIL badtgt%0d_recover: got valid=%0b pc=%h fault=%0b expected 1/0/0", t, out_valid, pc_out, fault); else passed++;
        end
    endtask

    task automatic test_end_of_rom();
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        branch_taken = 1'b1;
        branch_target = 32'hFF8;
        step();
        branch_taken = 1'b0;
        step();
        checks++; if (pc_out !== 32'hFF8 || instr_out !== rom[1022]) $display("[TB] FAIL eor_ff8: got %h/%h expected ff8/%h", pc_out, instr_out, rom[1022]); else passed++;
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        checks++; if (pc_out !== 32'hFFC || instr_out !== rom[1023] || out_valid !== 1'b1) $display("[TB] FAIL eor_ffc: got %h/%h v=%0b expected ffc/%h v=1", pc_out, instr_out, out_valid, rom[1023]); else passed++;
        out_ready = 1'b0;
        repeat (2) step();
        checks++; if (pc_out !== 32'hFFC || out_valid !== 1'b1 || fault !== 1'b0) $display("[TB] FAIL eor_ffc_stall: got %h v=%0b f=%0b expected ffc v=1 f=0", pc_out, out_valid, fault); else passed++;
        out_ready = 1'b1;
        step();
        checks++; if (fault !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL eor_fault: got fault=%0b valid=%0b expected 1/0", fault, out_valid); else passed++;
        checks++; if (fetch_count !== 32'd3) $display("[TB] FAIL eor_count: got %0d expected 3", fetch_count); else passed++;
        RESET = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        step();
        RESET = 1'b0;
        branch_taken = 1'b0;
        checks++; if (rom_addr !== 10'h0 || fault !== 1'b0) $display("[TB] FAIL eor_reset_branch: got addr=%h fault=%0b expected 0/0", rom_addr, fault); else passed++;
        step();
        step();
        checks++; if (pc_out !== 32'h0 || instr_out !== 32'hA0) $display("[TB] FAIL eor_refetch: got %h/%h expected 0/a0", pc_out, instr_out); else passed++;
    endtask

    task automatic test_reset_pc_fault();
        do_reset();
        checks++; if (fault2 !== 1'b0) $display("[TB] FAIL badpc_reset: got %0b expected 0", fault2); else passed++;
        step();
        checks++; if (fault2 !== 1'b1) $display("[TB] FAIL badpc_fault: got %0b expected 1", fault2); else passed++;
        out_ready = 1'b1;
        repeat (3) step();
        checks++; if (out_valid2 !== 1'b0 || fault2 !== 1'b1) $display("[TB] FAIL badpc_sticky: got valid=%0b fault=%0b expected 0/1", out_valid2, fault2); else passed++;
    endtask

    // Model: the accepted stream is sequential words starting at exp_pc; a branch
    // empties the output for one cycle and restarts the stream at its target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_count;
        logic        flushed;
        logic        exp_valid;
        int          tgt;
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        exp_pc = 32'h0;
        exp_count = 32'h0;
        flushed = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_valid = !flushed;
            checks++; if (out_valid !== exp_valid) $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", cyc, out_valid, exp_valid); else passed++;
            if (exp_valid) begin
                checks++; if (pc_out !== exp_pc) $display("[TB] FAIL rnd_pc@%0d: got %h expected %h", cyc, pc_out, exp_pc); else passed++;
                checks++; if (instr_out !== rom[exp_pc[11:2]]) $display("[TB] FAIL rnd_instr@%0d: got %h expected %h", cyc, instr_out, rom[exp_pc[11:2]]); else passed++;
            end
            checks++; if (fetch_count !== exp_count) $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", cyc, fetch_count, exp_count); else passed++;
            checks++; if (fault !== 1'b0) $display("[TB] FAIL rnd_fault@%0d: got %0b expected 0", cyc, fault); else passed++;
            out_ready = ($urandom_range(0, 9) < 7);
            branch_taken = ($urandom_range(0, 19) == 0);
            tgt = $urandom_range(0, 599);
            branch_target = 32'(tgt * 4);
            if (exp_valid && out_ready) begin
                exp_count = exp_count + 1;
                exp_pc = exp_pc + 4;
            end
            if (branch_taken) exp_pc = branch_target;
            flushed = branch_taken;
            step();
        end
        branch_taken = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        for (int i = 0; i < 4; i++) rom[i] = 32'hA0 + 32'(i);
        test_reset();
        test_startup();
        test_stall();
        test_branch_stall();
        test_bad_target();
        test_end_of_rom();
        test_reset_pc_fault();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
